// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss sequencer: pick the victim by miss count, write it back if dirty, refill it, then release the stall.
// Stall is combinational on a miss; memory handshakes (mem_ready/mem_valid) pace each word, and all WB outputs hold until mem_ready.
module dcache_miss_ctrl #(
    parameter int ADDRBITS      = 32,
    parameter int DATABITS      = 32,
    parameter int CACHEADDRBITS = 5,
    parameter int LSBITS        = 2,
    parameter int LINENUM       = 4,
    parameter int CNTMISSBITS   = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [ADDRBITS-1:0]             dcache_addr,
    input  logic                            dcache_rdreq,
    input  logic                            dcache_wrreq,
    output logic                            dcache_stall,
    input  logic [LINENUM-1:0]              line_miss,
    input  logic [LINENUM-1:0]              line_dirty,
    input  logic [LINENUM*CNTMISSBITS-1:0]  flush_cnt_miss,
    input  logic [LINENUM*ADDRBITS-1:0]     line_mem_addr,
    input  logic [LINENUM*DATABITS-1:0]     line_out,
    output logic [LINENUM-1:0]              flush_mode,
    output logic                            flush_write,
    output logic [CACHEADDRBITS-1:0]        flush_addr,
    output logic                            flush_dirty,
    output logic                            line_in_valid,
    output logic [ADDRBITS-1:0]             mem_addr,
    output logic [DATABITS-1:0]             mem_wdata,
    output logic                            mem_wrreq,
    output logic                            mem_rdreq,
    input  logic                            mem_ready,
    input  logic                            mem_valid
);

    localparam int TAGBITS = ADDRBITS - CACHEADDRBITS - LSBITS;
    localparam int VB      = (LINENUM > 1) ? $clog2(LINENUM) : 1;
    localparam logic [CACHEADDRBITS-1:0] LAST_WORD = {CACHEADDRBITS{1'b1}};

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_WB, S_FILL, S_DONE} state_t;

    state_t                   state, state_nxt;
    logic [CACHEADDRBITS-1:0] cnt;
    logic [LINENUM-1:0]       victim_oh;
    logic [VB-1:0]            victim_idx, sel_idx;
    logic [TAGBITS-1:0]       req_tag;
    logic                     req_wr;
    logic [CNTMISSBITS-1:0]   best_cnt;
    logic                     miss_req, cnt_last;
    logic [ADDRBITS-1:0]      wb_base;
    logic [DATABITS-1:0]      wb_data;
    logic                     unused_addr_bits;

    assign miss_req     = (dcache_rdreq | dcache_wrreq) & (&line_miss);
    assign cnt_last     = (cnt == LAST_WORD);
    assign dcache_stall = (state != S_IDLE) | miss_req;
    assign wb_base      = line_mem_addr[victim_idx*ADDRBITS +: ADDRBITS];
    assign wb_data      = line_out[victim_idx*DATABITS +: DATABITS];
    assign unused_addr_bits = ^dcache_addr[CACHEADDRBITS+LSBITS-1:0];

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
        sel_idx  = '0;
        best_cnt = flush_cnt_miss[0 +: CNTMISSBITS];
        for (int i = 1; i < LINENUM; i++) begin
            if (flush_cnt_miss[i*CNTMISSBITS +: CNTMISSBITS] > best_cnt) begin
                best_cnt = flush_cnt_miss[i*CNTMISSBITS +: CNTMISSBITS];
                sel_idx  = VB'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (miss_req) state_nxt = S_SELECT;
            S_SELECT: state_nxt = line_dirty[sel_idx] ? S_WB : S_FILL;
            S_WB:     if (mem_ready && cnt_last) state_nxt = S_FILL;
            S_FILL:   if (mem_valid && cnt_last) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            victim_oh  <= '0;
            victim_idx <= '0;
            req_tag    <= '0;
            req_wr     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss_req) begin
                        req_tag <= dcache_addr[ADDRBITS-1 -: TAGBITS];
                        req_wr  <= dcache_wrreq;
                    end
                end
                S_SELECT: begin
                    victim_oh  <= LINENUM'(1) << sel_idx;
                    victim_idx <= sel_idx;
                    cnt        <= '0;
                end
                S_WB:   if (mem_ready) cnt <= cnt_last ? '0 : cnt + CACHEADDRBITS'(1);
                S_FILL: if (mem_valid) cnt <= cnt_last ? '0 : cnt + CACHEADDRBITS'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        flush_mode    = '0;
        flush_write   = 1'b0;
        flush_addr    = '0;
        flush_dirty   = 1'b0;
        line_in_valid = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wrreq     = 1'b0;
        mem_rdreq     = 1'b0;
        case (state)
            S_WB: begin
                mem_wrreq  = 1'b1;
                mem_addr   = wb_base + ADDRBITS'({cnt, {LSBITS{1'b0}}});
                mem_wdata  = wb_data;
                flush_mode = victim_oh;
                flush_addr = cnt;
            end
            S_FILL: begin
                mem_rdreq     = 1'b1;
                mem_addr      = {req_tag, cnt, {LSBITS{1'b0}}};
                flush_mode    = victim_oh;
                flush_addr    = cnt;
                flush_write   = mem_valid;
                line_in_valid = mem_valid;
                flush_dirty   = mem_valid & req_wr;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl: a vector table for victim selection and hit/miss entry,
// plus hand sequences for full write-back/refill, handshake stalls and asynchronous abort.
module tb_dcache_miss_ctrl;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [31:0]  dcache_addr;
    logic         dcache_rdreq, dcache_wrreq, dcache_stall;
    logic [3:0]   line_miss, line_dirty;
    logic [31:0]  flush_cnt_miss;
    logic [127:0] line_mem_addr;
    logic [127:0] line_out;
    logic [3:0]   flush_mode;
    logic         flush_write, flush_dirty, line_in_valid;
    logic [4:0]   flush_addr;
    logic [31:0]  mem_addr, mem_wdata;
    logic         mem_wrreq, mem_rdreq, mem_ready, mem_valid;

    int n_cmp = 0;
    int n_err = 0;

    dcache_miss_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .dcache_addr(dcache_addr), .dcache_rdreq(dcache_rdreq), .dcache_wrreq(dcache_wrreq),
        .dcache_stall(dcache_stall),
        .line_miss(line_miss), .line_dirty(line_dirty), .flush_cnt_miss(flush_cnt_miss),
        .line_mem_addr(line_mem_addr), .line_out(line_out),
        .flush_mode(flush_mode), .flush_write(flush_write), .flush_addr(flush_addr),
        .flush_dirty(flush_dirty), .line_in_valid(line_in_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wrreq(mem_wrreq), .mem_rdreq(mem_rdreq),
        .mem_ready(mem_ready), .mem_valid(mem_valid)
    );

    always #5 clk = ~clk;

    // Line array model: each line returns a word tagged with its own index and the word index.
    always_comb begin
        for (int i = 0; i < 4; i++)
            line_out[i*32 +: 32] = 32'hA000_0000 | (32'(i) << 16) | 32'(flush_addr);
    end

    typedef struct {
        logic        rd, wr;
        logic [3:0]  miss;
        logic [31:0] cnt;
        logic [3:0]  dirty;
        logic [31:0] addr;
        logic        exp_stall;
        logic [3:0]  exp_oh;
        logic        exp_wb;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        dcache_rdreq = 1'b0;
        dcache_wrreq = 1'b0;
        mem_valid    = 1'b0;
        mem_ready    = 1'b0;
        reset_n      = 1'b0;
        tick();
        reset_n      = 1'b1;
    endtask

    // Entered one step after the edge that put the DUT in WB with word 0 pending.
    task automatic wb_run(input logic [31:0] base, input int vid, input int stall_word, input int stall_n);
        for (int w = 0; w < 32; w++) begin
            if (w == stall_word) begin
                for (int s = 0; s < stall_n; s++) begin
                    mem_ready = 1'b0;
                    mem_valid = 1'b1;
                    #1;
                    check("wb_hold_addr", mem_addr, base + 32'(4*w));
                    check("wb_hold_wrreq", mem_wrreq, 1);
                    check("wb_stray_valid_fw", flush_write, 0);
                    tick();
                end
                mem_valid = 1'b0;
            end
            mem_ready = 1'b1;
            #1;
            check("wb_addr", mem_addr, base + 32'(4*w));
            check("wb_wdata", mem_wdata, 32'hA000_0000 | (32'(vid) << 16) | 32'(w));
            tick();
        end
        mem_ready = 1'b0;
    endtask

    // Entered one step after the edge that put the DUT in FILL with word 0 pending.
    task automatic fill_run(input logic [31:0] base, input logic exp_dirty, input int gap_word);
        for (int w = 0; w < 32; w++) begin
            if (w == gap_word) begin
                mem_valid = 1'b0;
                mem_ready = 1'b1;
                #1;
                check("fill_stray_ready_fw", flush_write, 0);
                check("fill_stray_ready_addr", flush_addr, w);
                tick();
                mem_ready = 1'b0;
            end
            mem_valid = 1'b1;
            #1;
            check("fill_addr", mem_addr, base + 32'(4*w));
            check("fill_rdreq", mem_rdreq, 1);
            check("fill_strobes", {flush_write, line_in_valid}, 2'b11);
            check("fill_flush_addr", flush_addr, w);
            check("fill_dirty", flush_dirty, exp_dirty);
            tick();
        end
        mem_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rd    wr    miss     cnt_miss       dirty    addr          stall oh       wb    first mem addr
        vecs[0] = '{1'b1, 1'b0, 4'b1111, 32'h01_09_09_03, 4'b0000, 32'h0000_1284, 1'b1, 4'b0010, 1'b0, 32'h0000_1280};
        vecs[1] = '{1'b0, 1'b1, 4'b1111, 32'h00_10_05_05, 4'b0100, 32'h0000_2288, 1'b1, 4'b0100, 1'b1, 32'h0000_4000};
        vecs[2] = '{1'b1, 1'b0, 4'b1111, 32'h07_07_07_07, 4'b0001, 32'h0000_0000, 1'b1, 4'b0001, 1'b1, 32'h0000_1000};
        vecs[3] = '{1'b1, 1'b0, 4'b1111, 32'hFF_00_00_FE, 4'b1000, 32'h0000_0000, 1'b1, 4'b1000, 1'b1, 32'h0000_8000};
        vecs[4] = '{1'b1, 1'b0, 4'b1111, 32'h00_00_00_00, 4'b1110, 32'hABCD_EF7C, 1'b1, 4'b0001, 1'b0, 32'hABCD_EF00};
        vecs[5] = '{1'b1, 1'b0, 4'b1101, 32'h01_09_09_03, 4'b0000, 32'h0000_1284, 1'b0, 4'b0000, 1'b0, 32'h0000_0000};
        vecs[6] = '{1'b0, 1'b0, 4'b1111, 32'h01_09_09_03, 4'b0000, 32'h0000_1284, 1'b0, 4'b0000, 1'b0, 32'h0000_0000};
        vecs[7] = '{1'b1, 1'b1, 4'b1111, 32'h00_00_80_00, 4'b0000, 32'h0000_0004, 1'b1, 4'b0010, 1'b0, 32'h0000_0000};
        vecs[8] = '{1'b1, 1'b0, 4'b1111, 32'h09_09_03_01, 4'b1000, 32'h0000_1284, 1'b1, 4'b0100, 1'b0, 32'h0000_1280};

        line_mem_addr  = {32'h0000_8000, 32'h0000_4000, 32'h0000_2000, 32'h0000_1000};
        dcache_addr    = 32'h0;
        line_dirty     = 4'b0000;
        flush_cnt_miss = 32'h0;
        mem_ready      = 1'b0;
        mem_valid      = 1'b0;
        dcache_wrreq   = 1'b0;

        // Reset held with a pending miss: outputs quiet, stall follows the request.
        reset_n      = 1'b0;
        dcache_rdreq = 1'b1;
        line_miss    = 4'b1111;
        tick();
        tick();
        check("rst_mem_req", {mem_rdreq, mem_wrreq}, 2'b00);
        check("rst_flush_mode", flush_mode, 0);
        check("rst_flush_write", {flush_write, line_in_valid, flush_dirty}, 3'b000);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_stall_comb", dcache_stall, 1);
        reset_n = 1'b1;
        tick();
        dcache_rdreq = 1'b0;
        #1;
        check("rst_select_stall", dcache_stall, 1);
        check("rst_select_quiet", {mem_rdreq, mem_wrreq, flush_mode}, 6'b0);
        tick();
        check("rst_fill_entry", {mem_rdreq, flush_mode}, {1'b1, 4'b0001});

        // Vector table: stall on entry, then the victim and first transfer two edges later.
        for (int v = 0; v < 9; v++) begin
            do_reset();
            line_miss      = vecs[v].miss;
            flush_cnt_miss = vecs[v].cnt;
            line_dirty     = vecs[v].dirty;
            dcache_addr    = vecs[v].addr;
            dcache_rdreq   = vecs[v].rd;
            dcache_wrreq   = vecs[v].wr;
            #1;
            check($sformatf("vec%0d_stall", v), dcache_stall, vecs[v].exp_stall);
            tick();
            if (vecs[v].exp_stall) begin
                dcache_rdreq = 1'b0;
                dcache_wrreq = 1'b0;
                dcache_addr  = 32'hFFFF_FFFF;
                #1;
                check($sformatf("vec%0d_select_stall", v), dcache_stall, 1);
                tick();
                check($sformatf("vec%0d_victim", v), flush_mode, vecs[v].exp_oh);
                check($sformatf("vec%0d_req_kind", v), {mem_wrreq, mem_rdreq}, {vecs[v].exp_wb, ~vecs[v].exp_wb});
                check($sformatf("vec%0d_addr", v), mem_addr, vecs[v].exp_addr);
            end else begin
                #1;
                check($sformatf("vec%0d_hit_stall", v), dcache_stall, 0);
                check($sformatf("vec%0d_hit_quiet", v), {mem_rdreq, mem_wrreq, flush_mode}, 6'b0);
            end
        end

        // Simultaneous rd/wr counts as a write: first refill word carries flush_dirty.
        do_reset();
        line_miss = 4'b1111; flush_cnt_miss = 32'h0; line_dirty = 4'b0000; dcache_addr = 32'h0000_0100;
        dcache_rdreq = 1'b1; dcache_wrreq = 1'b1;
        tick(); tick();
        mem_valid = 1'b1;
        #1;
        check("rdwr_flush_dirty", {flush_write, flush_dirty}, 2'b11);
        mem_valid = 1'b0;

        // Clean miss, full refill, DONE, then back to IDLE with the stall dropped.
        do_reset();
        line_miss = 4'b1111; flush_cnt_miss = 32'h01_09_09_03; line_dirty = 4'b0000;
        dcache_addr = 32'h0000_1284; dcache_rdreq = 1'b1;
        tick(); tick();
        check("clean_victim", flush_mode, 4'b0010);
        fill_run(32'h0000_1280, 1'b0, -1);
        line_miss = 4'b1101;
        #1;
        check("clean_done_mode", {flush_mode, mem_rdreq}, 5'b0);
        check("clean_done_stall", dcache_stall, 1);
        tick();
        check("clean_idle_stall", dcache_stall, 0);
        dcache_rdreq = 1'b0;

        // Dirty miss with a delayed mem_ready, stray handshakes, then a write-caused refill.
        do_reset();
        line_miss = 4'b1111; flush_cnt_miss = 32'h00_10_05_05; line_dirty = 4'b0100;
        dcache_addr = 32'h0000_2288; dcache_wrreq = 1'b1;
        tick(); tick();
        check("dirty_victim", flush_mode, 4'b0100);
        wb_run(32'h0000_4000, 2, 5, 3);
        check("dirty_fill_mode", {mem_rdreq, mem_wrreq, flush_mode}, {2'b10, 4'b0100});
        fill_run(32'h0000_2280, 1'b1, 3);
        #1;
        check("dirty_done", {flush_mode, mem_rdreq, mem_wrreq}, 6'b0);
        dcache_wrreq = 1'b0;

        // Asynchronous abort at word 17 of a refill; the next miss restarts at word 0.
        do_reset();
        line_miss = 4'b1111; flush_cnt_miss = 32'h01_09_09_03; line_dirty = 4'b0000;
        dcache_addr = 32'h0000_1284; dcache_rdreq = 1'b1;
        tick(); tick();
        for (int w = 0; w < 17; w++) begin
            mem_valid = 1'b1;
            tick();
        end
        mem_valid = 1'b0;
        #1;
        check("abort_pre_addr", mem_addr, 32'h0000_12C4);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_rdreq", mem_rdreq, 0);
        check("abort_mode", flush_mode, 0);
        check("abort_addr", mem_addr, 0);
        tick();
        reset_n = 1'b1;
        tick(); tick();
        check("restart_flush_addr", flush_addr, 0);
        check("restart_addr", mem_addr, 32'h0000_1280);
        check("restart_rdreq", mem_rdreq, 1);
        dcache_rdreq = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_miss_ctrl.md
Name: dcache_miss_ctrl

Overview:
- Sequences miss handling for a data cache built from LINENUM dcache lines.
- On a request that misses every line, it picks a victim line by miss counter and writes the victim back to memory word by word if it is dirty.
- It then refills the victim from memory over the shared per-line flush/refill interface, then releases the stall.
- Sits between the line array, the CPU request port and the memory bus.

Parameters:
ADDRBITS, 32, address width
DATABITS, 32, data word width
CACHEADDRBITS, 5, word index bits per line (CACHESIZE=2**CACHEADDRBITS words)
LSBITS, 2, byte offset bits within a word
LINENUM, 4, number of cache lines
CNTMISSBITS, 8, width of each line's miss counter

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
dcache_addr  in  ADDRBITS  CPU request address
dcache_rdreq  in  1  CPU read request
dcache_wrreq  in  1  CPU write request
dcache_stall  out  1  CPU must hold its request
line_miss  in  LINENUM  per-line miss flag
line_dirty  in  LINENUM  per-line dirty flag
flush_cnt_miss  in  LINENUM*CNTMISSBITS  per-line miss counters, line i at [i*CNTMISSBITS +: CNTMISSBITS]
line_mem_addr  in  LINENUM*ADDRBITS  per-line write-back base address
line_out  in  LINENUM*DATABITS  per-line read data at flush_addr
flush_mode  out  LINENUM  one-hot select of the victim line
flush_write  out  1  refill word write strobe
flush_addr  out  CACHEADDRBITS  word index being flushed or filled
flush_dirty  out  1  refill was caused by a write
line_in_valid  out  1  refill data valid, equal to flush_write
mem_addr  out  ADDRBITS  memory word address
mem_wdata  out  DATABITS  write-back data
mem_wrreq  out  1  memory write request
mem_rdreq  out  1  memory read request
mem_ready  in  1  memory accepted the current write
mem_valid  in  1  memory read data valid (data goes to the lines' line_in directly)

Behaviour:
- Reset: state IDLE. All outputs 0, except dcache_stall, which is combinational per the stall rule below. Word counter, victim and latched request cleared.
- Reset mid-operation aborts immediately. No further mem requests are issued. Any partial line content is then undefined.
- States:
  - IDLE → SELECT: when (rdreq|wrreq) and line_miss all ones. Latch dcache_addr and wrreq (as req_wr).
  - IDLE, any line hits: no action, stall 0.
- SELECT (1 cycle):
  - Victim = line with the largest flush_cnt_miss; ties go to the lowest index.
  - Register the victim as one-hot.
  - Go to WB if line_dirty[victim], else FILL. Word counter = 0.
- WB:
  - Drive mem_wrreq=1, mem_addr=line_mem_addr[victim] + (cnt<<LSBITS), mem_wdata=line_out[victim], flush_mode=victim, flush_addr=cnt.
  - Hold all of these until mem_ready.
  - On mem_ready: cnt+1. If cnt == CACHESIZE-1, set cnt=0 and go to FILL.
- FILL:
  - Drive mem_rdreq=1, mem_addr={latched_addr[ADDRBITS-1:CACHEADDRBITS+LSBITS], cnt, LSBITS'b0}, flush_mode=victim, flush_addr=cnt.
  - On mem_valid: flush_write=line_in_valid=1 for that cycle, flush_dirty=req_wr, cnt+1.
  - After the last word (cnt == CACHESIZE-1): go to DONE.
  - mem_rdreq stays high while in FILL.
- DONE (1 cycle): flush_mode=0, then IDLE. The line re-evaluates its hit; the request then completes as a hit.
- dcache_stall = (state != IDLE) | ((rdreq|wrreq) & &line_miss).
- Word counter width is CACHEADDRBITS. The terminal compare is exactly CACHESIZE-1; no wrap past it.
- The mem_addr adder is ADDRBITS wide, overflow discarded.
- Simultaneous rdreq & wrreq on a miss: treated as a write (req_wr=1).
- Requests changing during stall are ignored; only the value latched in IDLE is used.
- mem_valid outside FILL and mem_ready outside WB are ignored.

Test Plan:
1. Reset with rdreq=1 and line_miss=4'b1111 → all registered outputs 0 while reset_n=0. Release reset → SELECT next cycle, dcache_stall=1.
2. Clean miss: cnt_miss={3,9,9,1}, none dirty, addr 0x0000_1284, rdreq → victim one-hot 4'b0010. 32 FILL reads at 0x1280..0x12FC, with 32 flush_write pulses, flush_dirty=0. DONE, then IDLE, stall drops.
3. Dirty miss, victim 2, line_mem_addr[2]=0x0000_4000, wrreq → 32 writes 0x4000..0x407C. mem_ready delayed 3 cycles on word 5 holds mem_addr=0x4014 stable. Then the fill follows with flush_dirty=1.
4. Hit on line 1 (line_miss=4'b1101), rdreq → no mem traffic, stall=0 throughout.
5. mem_valid pulses in WB and mem_ready pulses in FILL → no counter change and no flush_write.
6. Assert reset_n=0 at word 17 of FILL → state IDLE and mem_rdreq=0 immediately (asynchronous). The next miss restarts at word 0.
